fib_seq_ctrl: RTL and testbench

//   Sequencer for the 8-bit Fibonacci generator datapath. Clears the datapath,

---
 rtl/fib_seq_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_fib_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_ctrl.sv
// Sequencer for the 8-bit Fibonacci datapath: clear, paced steps, valid/ready term output.
// Optional build macro FIB_OVF_STOP_EN: end the sequence on wrap instead of presenting the wrapped term.
module fib_seq_ctrl #(
    parameter int unsigned      CNT_W      = 20,
    parameter logic [CNT_W-1:0] DECIMATION = CNT_W'(20),
    parameter int unsigned      DATA_W     = 8,
    parameter int unsigned      TERMS_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [TERMS_W-1:0] n_terms,
    output logic               fib_clr,
    output logic               fib_step,
    input  logic [DATA_W-1:0]  fib_val,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TERMS_W-1:0] term_idx,
    output logic               busy,
    output logic               done,
    output logic               ovf
);

    // A zero gap would never let WAIT expire, so it behaves like a gap of one.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (DECIMATION == '0) ? '0 : DECIMATION - CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_HOLD = 3'd3,
        ST_WAIT = 3'd4,
        ST_STEP = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [TERMS_W-1:0] idx_q;
    logic [TERMS_W-1:0] idx_d;
    logic [TERMS_W-1:0] nlat_q;
    logic [TERMS_W-1:0] nlat_d;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  data_d;
    logic               ovf_q;
    logic               ovf_d;

    logic               start_ok_c;
    logic               hs_c;
    logic               last_c;
    logic               wrap_c;
    logic               gap_end_c;

    // Qualified events used by both the next-state and datapath logic.
    always_comb begin
        start_ok_c = start && !abort;
        hs_c       = (state_q == ST_HOLD) && out_ready;
        last_c     = (idx_q == (nlat_q - TERMS_W'(1)));
        wrap_c     = (idx_q != '0) && (fib_val < data_q);
        gap_end_c  = (cnt_q == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_ok_c) begin
                        state_d = (n_terms == '0) ? ST_DONE : ST_CLR;
                    end
                end
                ST_CLR:  state_d = ST_LOAD;
                ST_LOAD: begin
`ifdef FIB_OVF_STOP_EN
                    state_d = wrap_c ? ST_DONE : ST_HOLD;
`else
                    state_d = ST_HOLD;
`endif
                end
                ST_HOLD: begin
                    if (hs_c) begin
                        state_d = last_c ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (gap_end_c) begin
                        state_d = ST_STEP;
                    end
                end
                ST_STEP: state_d = ST_LOAD;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        fib_clr   = 1'b0;
        fib_step  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        busy      = (state_q != ST_IDLE);
        unique case (state_q)
            ST_CLR:  fib_clr   = 1'b1;
            ST_STEP: fib_step  = 1'b1;
            ST_HOLD: out_valid = 1'b1;
            ST_DONE: done      = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: counter, term index, latched length, term and wrap flag.
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        nlat_d = nlat_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        if (!abort) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_ok_c) begin
                        nlat_d = n_terms;
                        ovf_d  = 1'b0;
                    end
                end
                ST_CLR: idx_d = '0;
                ST_LOAD: begin
`ifdef FIB_OVF_STOP_EN
                    // The wrapped term is never presented, so it is not captured either.
                    if (wrap_c) begin
                        ovf_d = 1'b1;
                    end else begin
                        data_d = fib_val;
                    end
`else
                    data_d = fib_val;
                    if (wrap_c) begin
                        ovf_d = 1'b1;
                    end
`endif
                end
                ST_HOLD: begin
                    if (hs_c) begin
                        cnt_d = '0;
                        if (!last_c) begin
                            idx_d = idx_q + TERMS_W'(1);
                        end
                    end
                end
                ST_WAIT: cnt_d = cnt_q + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            nlat_q <= '0;
            data_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            nlat_q <= nlat_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_data = data_q;
    assign term_idx = idx_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl with a behavioural 8-bit Fibonacci datapath (DECIMATION=20).
module tb_fib_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] n_terms;
    logic       fib_clr;
    logic       fib_step;
    logic [7:0] fib_val;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] term_idx;
    logic       busy;
    logic       done;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    fib_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .n_terms   (n_terms),
        .fib_clr   (fib_clr),
        .fib_step  (fib_step),
        .fib_val   (fib_val),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .term_idx  (term_idx),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: term value valid the cycle after clr/step.
    logic [7:0] cur;
    logic [7:0] nxt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= 8'd0;
            nxt <= 8'd0;
        end else if (fib_clr) begin
            cur <= 8'd0;
            nxt <= 8'd1;
        end else if (fib_step) begin
            cur <= nxt;
            nxt <= cur + nxt;
        end
    end
    assign fib_val = cur;

    // Event monitor sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   hs_data[$];
    int   hs_idx[$];
    int   hs_cyc[$];
    int   vr_cyc[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   step_cnt = 0;
    int   clr_cnt  = 0;
    int   clr_cyc  = 0;
    int   v121_cnt = 0;
    logic prev_v   = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                hs_data.push_back(int'(out_data));
                hs_idx.push_back(int'(term_idx));
                hs_cyc.push_back(cyc);
            end
            if (out_valid && !prev_v) vr_cyc.push_back(cyc);
            if (out_valid && (out_data == 8'd121)) v121_cnt = v121_cnt + 1;
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (fib_step) step_cnt = step_cnt + 1;
            if (fib_clr) begin
                clr_cnt = clr_cnt + 1;
                clr_cyc = cyc;
            end
        end
        prev_v = out_valid;
    end

    // Snapshot of monitor state at the start of each test.
    int hs_b, vr_b, done_b, step_b, clr_b, v121_b;

    task automatic snap();
        hs_b   = hs_data.size();
        vr_b   = vr_cyc.size();
        done_b = done_cnt;
        step_b = step_cnt;
        clr_b  = clr_cnt;
        v121_b = v121_cnt;
    endtask

    function automatic int hsd(input int i);
        return (hs_b + i < hs_data.size()) ? hs_data[hs_b + i] : -1;
    endfunction
    function automatic int hsi(input int i);
        return (hs_b + i < hs_idx.size()) ? hs_idx[hs_b + i] : -1;
    endfunction
    function automatic int hsc(input int i);
        return (hs_b + i < hs_cyc.size()) ? hs_cyc[hs_b + i] : -1;
    endfunction
    function automatic int vrc(input int i);
        return (vr_b + i < vr_cyc.size()) ? vr_cyc[vr_b + i] : -1;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        if (obs != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, int'(busy), 0);
    endtask

    task automatic do_start(input logic [7:0] n);
        n_terms = n;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        n_terms = 8'd99;
    endtask

    localparam int EXP5[5] = '{0, 1, 1, 2, 3};

    initial begin
        int n;
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        n_terms   = 8'd0;
        out_ready = 1'b0;

        // Test 1: reset values, then a 5-term run at full throughput.
        #19;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy",      int'(busy),      0);
        check("rst_done",      int'(done),      0);
        check("rst_fib_clr",   int'(fib_clr),   0);
        check("rst_fib_step",  int'(fib_step),  0);
        check("rst_out_data",  int'(out_data),  0);
        check("rst_term_idx",  int'(term_idx),  0);
        check("rst_ovf",       int'(ovf),       0);
        #1 reset = 1'b1;
        tick();
        snap();
        out_ready = 1'b1;
        do_start(8'd5);
        check("t1_fib_clr", int'(fib_clr), 1);
        wait_idle(300, "t1_timeout");
        check("t1_hs_count", hs_data.size() - hs_b, 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t1_data%0d", i), hsd(i), EXP5[i]);
            check($sformatf("t1_idx%0d", i),  hsi(i), i);
        end
        check("t1_clr_to_valid", vrc(0) - clr_cyc, 2);
        for (int i = 0; i < 4; i++)
            check($sformatf("t1_gap%0d", i), vrc(i + 1) - vrc(i), 23);
        check("t1_done_count", done_cnt - done_b, 1);
        check("t1_done_lat",   done_cyc - hsc(4), 1);
        check("t1_ovf",        int'(ovf), 0);

        // Test 2: backpressure while term 2 is presented.
        snap();
        do_start(8'd4);
        n = 0;
        while (!(term_idx == 8'd2 && !out_valid) && n < 200) begin tick(); n++; end
        check("t2_reach_idx2", int'(term_idx), 2);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        check("t2_valid", int'(out_valid), 1);
        check("t2_stall_data0", int'(out_data), 1);
        step_b = step_cnt;
        repeat (10) tick();
        check("t2_stall_data1", int'(out_data), 1);
        check("t2_stall_idx",   int'(term_idx), 2);
        check("t2_stall_valid", int'(out_valid), 1);
        check("t2_no_step",     step_cnt - step_b, 0);
        out_ready = 1'b1;
        wait_idle(200, "t2_timeout");
        check("t2_hs_count", hs_data.size() - hs_b, 4);
        check("t2_data2", hsd(2), 1);
        check("t2_data3", hsd(3), 2);
        check("t2_done",  done_cnt - done_b, 1);

        // Test 3: 15 terms, term 14 wraps to 121.
        snap();
        do_start(8'd15);
        wait_idle(600, "t3_timeout");
        check("t3_term13", hsd(13), 233);
        check("t3_ovf",    int'(ovf), 1);
        check("t3_done",   done_cnt - done_b, 1);
`ifdef FIB_OVF_STOP_EN
        check("t3_hs_count", hs_data.size() - hs_b, 14);
        check("t3_no_121",   v121_cnt - v121_b, 0);
`else
        check("t3_hs_count", hs_data.size() - hs_b, 15);
        check("t3_term14",   hsd(14), 121);
`endif

        // Test 4: abort during WAIT after term 1, then a fresh run.
        snap();
        do_start(8'd5);
        check("t4_ovf_cleared", int'(ovf), 0);
        n = 0;
        while (!((hs_data.size() - hs_b) == 2 && !out_valid) && n < 200) begin tick(); n++; end
        check("t4_reach_wait", hs_data.size() - hs_b, 2);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_busy",  int'(busy), 0);
        check("t4_valid", int'(out_valid), 0);
        repeat (5) tick();
        check("t4_no_done", done_cnt - done_b, 0);
        snap();
        do_start(8'd3);
        wait_idle(200, "t4_timeout");
        check("t4_first", hsd(0), 0);
        check("t4_count", hs_data.size() - hs_b, 3);
        check("t4_done",  done_cnt - done_b, 1);

        // Test 5: zero-length run goes straight to done.
        snap();
        do_start(8'd0);
        check("t5_done",    int'(done), 1);
        check("t5_busy",    int'(busy), 1);
        check("t5_fib_clr", int'(fib_clr), 0);
        tick();
        check("t5_busy_after", int'(busy), 0);
        check("t5_done_after", int'(done), 0);
        check("t5_no_clr",   clr_cnt - clr_b, 0);
        check("t5_no_valid", vr_cyc.size() - vr_b, 0);

        // Test 6: asynchronous reset while a term is held.
        snap();
        do_start(8'd5);
        n = 0;
        while (!(term_idx == 8'd3 && !out_valid) && n < 200) begin tick(); n++; end
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        check("t6_pre_data", int'(out_data), 2);
        #2 reset = 1'b0;
        #1;
        check("t6_valid", int'(out_valid), 0);
        check("t6_busy",  int'(busy), 0);
        check("t6_data",  int'(out_data), 0);
        check("t6_idx",   int'(term_idx), 0);
        check("t6_no_done", done_cnt - done_b, 0);
        tick();
        reset = 1'b1;
        tick();
        snap();
        out_ready = 1'b1;
        do_start(8'd2);
        wait_idle(200, "t6_timeout");
        check("t6_count", hs_data.size() - hs_b, 2);
        check("t6_d0", hsd(0), 0);
        check("t6_d1", hsd(1), 1);
        check("t6_done", done_cnt - done_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
